// File: rtl/ff256_lincomb_accum_pkg.sv
// Shared GF(2^8) constants, FSM state type and register map for the
// constant-multiplier peripheral and the linear-combination accumulator.
package ff256_mult_by_const_defines;

    // Field reduction polynomial x^8+x^4+x^3+x^2+1 (low byte), BETA_k = alpha^k.
    localparam logic [7:0] GF_POLY = 8'h1D;

    localparam logic [7:0] BETA_1  = 8'h02;
    localparam logic [7:0] BETA_2  = 8'h04;
    localparam logic [7:0] BETA_3  = 8'h08;
    localparam logic [7:0] BETA_4  = 8'h10;
    localparam logic [7:0] BETA_6  = 8'h40;
    localparam logic [7:0] BETA_8  = 8'h1D;
    localparam logic [7:0] BETA_9  = 8'h3A;
    localparam logic [7:0] BETA_12 = 8'hCD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MAC   = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

    localparam logic [1:0] ADR_FIFO   = 2'b00;
    localparam logic [1:0] ADR_CTRL   = 2'b01;
    localparam logic [1:0] ADR_RESULT = 2'b10;
    localparam logic [1:0] ADR_STATUS = 2'b11;

    localparam logic [1:0] STAT_IDLE  = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_DONE  = 2'b10;
    localparam logic [1:0] STAT_ERROR = 2'b11;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // With a constant operand this folds to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Index = {word parity, lane}.
    function automatic logic [7:0] beta_sel(input int idx);
        case (idx)
            0:       return BETA_1;
            1:       return BETA_2;
            2:       return BETA_3;
            3:       return BETA_4;
            4:       return BETA_6;
            5:       return BETA_8;
            6:       return BETA_9;
            7:       return BETA_12;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ff256_mult_by_const_multiplier.sv
// GF(2^8) multiply of a byte by a compile-time constant.
// Ports: a_i operand byte, p_o product byte.
module ff256_mult_by_const_multiplier
    import ff256_mult_by_const_defines::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/ff256_word_fifo.sv
// Word FIFO with synchronous reset and flush.
// Ports: clk, reset, flush_i, push_i/data_i, pop_i/data_o, full_o, empty_o, level_o.
module ff256_word_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_pop;
    logic          do_push;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign data_o  = mem_q[rd_q];

    // A full FIFO still takes a push when a pop frees a slot this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ff256_lincomb_accum.sv
// Wishbone slave computing y = XOR_k BETA_k * x_k byte-serially over N FIFO words.
// Ports: clk, reset, Wishbone adr/data/we/sel/stb/cyc/ack, status_o (00 idle 01 busy 10 done 11 error).
module ff256_lincomb_accum
    import ff256_mult_by_const_defines::*;
#(
    parameter int BUS_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  adr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   sel_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic [1:0]            status_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [7:0]            acc_q, acc_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [1:0]            lane_q, lane_d;
    logic [7:0]            n_q, n_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  ack_q;
    logic                  pend_q, pend_d;
    logic [7:0]            pend_n_q, pend_n_d;

    logic                  access;
    logic                  wr_fifo;
    logic                  wr_ctrl;
    logic                  clear;
    logic                  start_req;
    logic [7:0]            start_n;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd;
    logic [LW-1:0]         fifo_lvl;
    logic [3:0]            lvl4;
    logic [7:0]            cur_byte;
    logic [7:0]            mac_term;
    logic [7:0]            prod [8];
    logic                  unused_sel;

    assign unused_sel = ^sel_i;

    assign access  = stb_i && cyc_i && !ack_q;
    assign wr_fifo = access && we_i && (adr_i == ADR_FIFO);
    assign wr_ctrl = access && we_i && (adr_i == ADR_CTRL);
    assign clear   = wr_ctrl && data_i[1];

    // A START that arrived together with CLEAR is replayed one cycle later.
    assign start_req = pend_q || (wr_ctrl && data_i[0]);
    assign start_n   = pend_q ? pend_n_q : data_i[15:8];

    ff256_word_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (wr_fifo),
        .pop_i   (fifo_pop),
        .data_i  (data_i),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    assign cur_byte = word_q[{lane_q, 3'b000} +: 8];

    for (genvar g = 0; g < 8; g++) begin : g_mul
        ff256_mult_by_const_multiplier #(
            .COEF (beta_sel(g))
        ) u_mul (
            .a_i (cur_byte),
            .p_o (prod[g])
        );
    end

    // Word parity is the LSB of the count of words already finished.
    assign mac_term = prod[{cnt_q[0], lane_q}];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        word_d   = word_q;
        lane_d   = lane_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        pend_d   = 1'b0;
        pend_n_d = pend_n_q;
        fifo_pop = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            acc_d    = 8'h00;
            cnt_d    = 8'h00;
            ovf_d    = 1'b0;
            pend_d   = data_i[0];
            pend_n_d = data_i[15:8];
        end else begin
            unique case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_req) begin
                        if (start_n != 8'd0) begin
                            state_d = FETCH;
                            acc_d   = 8'h00;
                            n_d     = start_n;
                            cnt_d   = 8'h00;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end
                FETCH: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        word_d   = fifo_rd;
                        lane_d   = 2'd0;
                        state_d  = MAC;
                    end
                end
                MAC: begin
                    acc_d  = acc_q ^ mac_term;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = (cnt_q + 8'd1 == n_q) ? DONE : FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (wr_fifo && fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= 8'h00;
            word_q   <= '0;
            lane_q   <= 2'd0;
            n_q      <= 8'h00;
            cnt_q    <= 8'h00;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
            pend_n_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            lane_q   <= lane_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ack_q    <= access;
            pend_q   <= pend_d;
            pend_n_q <= pend_n_d;
        end
    end

    assign ack_o = ack_q;

    // Overflow dominates the reported status until cleared.
    always_comb begin
        status_o = STAT_IDLE;
        if (ovf_q) begin
            status_o = STAT_ERROR;
        end else begin
            unique case (state_q)
                IDLE:       status_o = STAT_IDLE;
                FETCH, MAC: status_o = STAT_BUSY;
                DONE:       status_o = STAT_DONE;
                ERROR:      status_o = STAT_ERROR;
                default:    status_o = STAT_IDLE;
            endcase
        end
    end

    assign lvl4 = 4'(fifo_lvl);

    always_comb begin
        data_o = '0;
        unique case (adr_i)
            ADR_RESULT: data_o = {14'd0, status_o, 8'd0, acc_q};
            ADR_STATUS: data_o = {16'd0, 7'd0, ovf_q, 4'd0, lvl4};
            default:    data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_ff256_lincomb_accum.sv
// Self-checking bench for ff256_lincomb_accum: transaction-level model
// plus directed vectors with hand-computed results.
module tb_ff256_lincomb_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  adr_i = 2'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = 4'hF;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        ack_o;
    logic [1:0]  status_o;

    int n_run = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ff256_lincomb_accum #(
        .BUS_WIDTH  (2),
        .DATA_WIDTH (32),
        .BE_WIDTH   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .adr_i    (adr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .we_i     (we_i),
        .sel_i    (sel_i),
        .stb_i    (stb_i),
        .cyc_i    (cyc_i),
        .ack_o    (ack_o),
        .status_o (status_o)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Reference field arithmetic: shift-and-add, poly 0x11D.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] dot(input logic [31:0] w, input bit odd);
        logic [7:0] ce [4];
        logic [7:0] co [4];
        logic [7:0] r;
        ce = '{8'h02, 8'h04, 8'h08, 8'h10};
        co = '{8'h40, 8'h1D, 8'h3A, 8'hCD};
        r = 8'h00;
        for (int i = 0; i < 4; i++)
            r = r ^ gmul(w[8*i +: 8], odd ? co[i] : ce[i]);
        return r;
    endfunction

    // Model: queue for the FIFO, whole-word dot product after 5 cycles.
    logic [31:0] m_q [$];
    bit          m_ack;
    bit          m_ovf;
    int          m_code;
    logic [7:0]  m_acc;
    int          m_phase;
    int          m_k;
    int          m_n;
    logic [31:0] m_cur;
    bit          m_pend;
    int          m_pend_n;

    always @(posedge clk) begin
        bit acc_ev;
        bit wr;
        bit popped;
        bit start;
        int n;
        if (reset) begin
            m_q.delete();
            m_ack = 0; m_ovf = 0; m_code = 0; m_acc = 8'h00;
            m_phase = 0; m_k = 0; m_n = 0; m_pend = 0; m_pend_n = 0;
            m_cur = 32'd0;
        end else begin
            acc_ev = stb_i && cyc_i && !m_ack;
            wr = acc_ev && we_i;
            popped = 0;
            if (wr && adr_i == 2'd1 && data_i[1]) begin
                m_q.delete();
                m_ovf = 0; m_code = 0; m_acc = 8'h00;
                m_pend = data_i[0];
                m_pend_n = int'(data_i[15:8]);
            end else begin
                start = m_pend || (wr && adr_i == 2'd1 && data_i[0]);
                n = m_pend ? m_pend_n : int'(data_i[15:8]);
                m_pend = 0;
                if (m_code != 1) begin
                    if (start) begin
                        if (n != 0) begin
                            m_code = 1; m_acc = 8'h00; m_n = n;
                            m_k = 0; m_phase = 0;
                        end else begin
                            m_code = 3;
                        end
                    end
                end else if (m_phase == 0) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        popped = 1;
                        m_phase = 1;
                    end
                end else if (m_phase < 4) begin
                    m_phase++;
                end else begin
                    m_acc = m_acc ^ dot(m_cur, (m_k % 2) != 0);
                    m_k++;
                    m_phase = 0;
                    if (m_k == m_n) m_code = 2;
                end
                if (wr && adr_i == 2'd0) begin
                    if (m_q.size() < 4 || popped) m_q.push_back(data_i);
                    else m_ovf = 1;
                end
            end
            m_ack = acc_ev;
        end
    end

    always @(negedge clk) begin
        logic [1:0] es;
        if (chk_en && !reset) begin
            es = m_ovf ? 2'd3 : 2'(m_code);
            chk("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
            chk("status_o", {30'd0, status_o}, {30'd0, es});
            case (adr_i)
                2'd2: if (m_code != 1)
                    chk("rd_result", data_o, {14'd0, es, 8'd0, m_acc});
                2'd3: chk("rd_status", data_o,
                          {23'd0, m_ovf, 4'd0, 4'(m_q.size())});
                default: chk("rd_zero", data_o, 32'd0);
            endcase
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        adr_i = a; data_i = d; we_i = 1; stb_i = 1; cyc_i = 1;
        @(posedge clk); #1;
        we_i = 0; stb_i = 0; cyc_i = 0; adr_i = 2'd0; data_i = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        adr_i = a; we_i = 0; stb_i = 1; cyc_i = 1;
        @(negedge clk);
        d = data_o;
        @(posedge clk); #1;
        stb_i = 0; cyc_i = 0; adr_i = 2'd0;
        @(posedge clk); #1;
    endtask

    // Called one edge after the access edge; returns cycles since that edge.
    task automatic wait_done(input int lim, output int c);
        c = 1;
        while (status_o != 2'b10 && c < lim) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int c;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;

        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_status", {30'd0, status_o}, 32'd0);
        rd(2'd2, d); chk("rst_result", d, 32'd0);
        rd(2'd3, d); chk("rst_fifo", d, 32'd0);

        wr(2'd0, 32'h0000_0001);
        wr(2'd1, 32'h0000_0101);
        chk("t1_busy", {30'd0, status_o}, 32'd1);
        wait_done(40, c);
        chk("t1_latency", c, 5);
        rd(2'd2, d); chk("t1_acc", d, 32'h0002_0002);

        wr(2'd0, 32'h0000_0101);
        wr(2'd0, 32'h0100_0000);
        wr(2'd1, 32'h0000_0201);
        wait_done(80, c);
        chk("t2_latency", c, 10);
        rd(2'd2, d); chk("t2_acc", d, 32'h0002_00CB);

        for (int i = 0; i < 5; i++) wr(2'd0, 32'h10 + i);
        chk("ovf_status", {30'd0, status_o}, 32'd3);
        rd(2'd3, d); chk("ovf_level", d, 32'h0000_0104);
        wr(2'd1, 32'h0000_0002);
        rd(2'd3, d); chk("clr_level", d, 32'd0);
        chk("clr_status", {30'd0, status_o}, 32'd0);

        wr(2'd1, 32'h0000_0001);
        chk("n0_error", {30'd0, status_o}, 32'd3);
        rd(2'd2, d); chk("n0_result", d, 32'h0003_0000);
        wr(2'd1, 32'h0000_0103);
        chk("cs_busy", {30'd0, status_o}, 32'd1);
        repeat (20) @(posedge clk);
        #1 chk("fetch_hold", {30'd0, status_o}, 32'd1);
        wr(2'd0, 32'h0000_0003);
        wait_done(40, c);
        chk("t3_latency", c, 5);
        rd(2'd2, d); chk("t3_acc", d, 32'h0002_0006);

        wr(2'd0, 32'h1122_3344);
        wr(2'd0, 32'h5566_7788);
        wr(2'd0, 32'h99AA_BBCC);
        wr(2'd1, 32'h0000_0301);
        repeat (7) @(posedge clk);
        #1 chk("pre_rst_busy", {30'd0, status_o}, 32'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("mid_rst_status", {30'd0, status_o}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack_o}, 32'd0);
        rd(2'd3, d); chk("mid_rst_fifo", d, 32'd0);
        rd(2'd2, d); chk("mid_rst_result", d, 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
